bram_8_rd_stream: RTL and testbench

Streaming reader for the 8-bit side of the 8 KB dual-port frame buffer. It accepts a (start address, byte count) command, issues byte reads on the buffer's 8-bit port (1-cycle read latency), and delivers the bytes in order on a valid/ready byte stream. It is the consumer counterpart to the 64-bit writer. A small output FIFO absorbs downstream backpressure without losing reads already in flight.

---
 rtl/bram_8_rd_stream.sv | 223 ++++++++++++++++++++++
 tb/tb_bram_8_rd_stream.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_8_rd_stream.sv
// bram_8_rd_stream
// Streaming reader for the 8-bit port of the 8 KB dual-port frame buffer.
// A (start address, byte count) command is turned into consecutive byte
// reads (address wraps 8191 -> 0). The returned bytes travel through a small
// output FIFO onto a valid/ready byte stream.
// Reads are issued only while the FIFO has room for every byte already
// requested. A read in flight therefore always has a slot waiting, and
// downstream backpressure can never cause a byte to be lost.
//
// Optional feature macro: BRAM_RD_STREAM_LAST_EN
//   defined   - each FIFO entry carries a last flag, and last_out marks the
//               final byte of every command
//   undefined - no flag storage, last_out is tied low, and done_out is the
//               only end-of-command marker

module bram_8_rd_stream #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        cmd_valid_in,
    output logic        cmd_ready_out,
    input  logic [12:0] cmd_addr_in,
    input  logic [13:0] cmd_len_in,
    output logic        en_b_out,
    output logic [12:0] addr_b_out,
    output logic        we_b_out,
    input  logic [7:0]  rd_d_b_in,
    output logic [7:0]  data_out,
    output logic        valid_out,
    input  logic        ready_in,
    output logic        last_out,
    output logic        done_out
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t            state_reg;
    state_t            state_next;

    logic [12:0]       addr_cur_reg;     // next address to issue
    logic [12:0]       addr_last_reg;    // last address driven, held while idle
    logic [13:0]       remaining_reg;    // reads still to be issued
    logic              inflight_reg;     // a read was issued last cycle
    logic              done_reg;

    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  fifo_count_reg;
    logic [7:0]        fifo_data [FIFO_DEPTH];

    logic              cmd_hs;
    logic              issue;
    logic              push;
    logic              pop;
    logic              final_xfer;
    logic [CNT_W-1:0]  occupancy;

    // Handshake, issue, FIFO strobes and end-of-command detection
    always_comb begin
        cmd_hs     = cmd_valid_in && (state_reg == ST_IDLE);
        occupancy  = fifo_count_reg + CNT_W'(inflight_reg);
        issue      = (state_reg == ST_READ) && (occupancy < DEPTH_C);
        push       = inflight_reg;
        pop        = valid_out && ready_in;
        // In DRAIN nothing more is requested, so the command has ended
        // once the only byte left in the FIFO leaves it.
        final_xfer = (state_reg == ST_DRAIN) && pop && !inflight_reg
                     && (fifo_count_reg == CNT_W'(1));
    end

    // State register
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE: begin
                if (cmd_hs && (cmd_len_in != 14'd0)) begin
                    state_next = ST_READ;
                end
            end
            ST_READ: begin
                if (issue && (remaining_reg == 14'd1)) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (final_xfer) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Address / byte counter: load on command, advance on every issue
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            addr_cur_reg  <= '0;
            addr_last_reg <= '0;
            remaining_reg <= '0;
        end else if (cmd_hs) begin
            addr_cur_reg  <= cmd_addr_in;
            remaining_reg <= cmd_len_in;
        end else if (issue) begin
            addr_cur_reg  <= addr_cur_reg + 13'd1;
            addr_last_reg <= addr_cur_reg;
            remaining_reg <= remaining_reg - 14'd1;
        end
    end

    // In-flight tracking and the completion pulse
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            inflight_reg <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            inflight_reg <= issue;
            done_reg     <= (cmd_hs && (cmd_len_in == 14'd0)) || final_xfer;
        end
    end

    // FIFO pointers and occupancy; a push and a pop together leave count unchanged
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            fifo_count_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count_reg <= fifo_count_reg + CNT_W'(1);
                2'b01:   fifo_count_reg <= fifo_count_reg - CNT_W'(1);
                default: fifo_count_reg <= fifo_count_reg;
            endcase
        end
    end

    // FIFO storage, one register per entry so the head reads 0 straight after reset
    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
            logic [7:0] data_reg;

            // Capture returning read data when this entry is the write slot
            always_ff @(posedge clk_in or negedge rst_n_in) begin
                if (!rst_n_in) begin
                    data_reg <= '0;
                end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
                    data_reg <= rd_d_b_in;
                end
            end

            assign fifo_data[gi] = data_reg;
        end
    endgenerate

`ifdef BRAM_RD_STREAM_LAST_EN
    logic fifo_last [FIFO_DEPTH];
    logic inflight_last_reg;

    // Remember whether the read in flight is the final byte of its command
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            inflight_last_reg <= 1'b0;
        end else begin
            inflight_last_reg <= issue && (remaining_reg == 14'd1);
        end
    end

    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_last
            logic last_reg;

            // Last flag travels alongside its byte
            always_ff @(posedge clk_in or negedge rst_n_in) begin
                if (!rst_n_in) begin
                    last_reg <= 1'b0;
                end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
                    last_reg <= inflight_last_reg;
                end
            end

            assign fifo_last[gi] = last_reg;
        end
    endgenerate

    assign last_out = valid_out && fifo_last[rd_ptr_reg];
`else
    assign last_out = 1'b0;
`endif

    // Outputs
    assign cmd_ready_out = (state_reg == ST_IDLE);
    assign en_b_out      = issue;
    assign addr_b_out    = issue ? addr_cur_reg : addr_last_reg;
    assign we_b_out      = 1'b0;
    assign valid_out     = (fifo_count_reg != '0);
    assign data_out      = fifo_data[rd_ptr_reg];
    assign done_out      = done_reg;

endmodule

// File: tb/tb_bram_8_rd_stream.sv
// tb_bram_8_rd_stream
// Drives commands into bram_8_rd_stream against a behavioural frame-buffer
// memory. Every accepted command expands into the address and byte sequence
// it should produce, and a negedge monitor compares that sequence with what
// the DUT actually drives. Define BRAM_RD_STREAM_LAST_EN to exercise last_out.
`timescale 1ns/1ps

module tb_bram_8_rd_stream;

    localparam int FIFO_DEPTH = 4;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        cmd_valid_in;
    logic        cmd_ready_out;
    logic [12:0] cmd_addr_in;
    logic [13:0] cmd_len_in;
    logic        en_b_out;
    logic [12:0] addr_b_out;
    logic        we_b_out;
    logic [7:0]  rd_d_b_in;
    logic [7:0]  data_out;
    logic        valid_out;
    logic        ready_in;
    logic        last_out;
    logic        done_out;

    bram_8_rd_stream #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .cmd_valid_in  (cmd_valid_in),
        .cmd_ready_out (cmd_ready_out),
        .cmd_addr_in   (cmd_addr_in),
        .cmd_len_in    (cmd_len_in),
        .en_b_out      (en_b_out),
        .addr_b_out    (addr_b_out),
        .we_b_out      (we_b_out),
        .rd_d_b_in     (rd_d_b_in),
        .data_out      (data_out),
        .valid_out     (valid_out),
        .ready_in      (ready_in),
        .last_out      (last_out),
        .done_out      (done_out)
    );

    always #5 clk_in = ~clk_in;

    // Frame-buffer model: 1-cycle read latency
    logic [7:0] mem [8192];
    always @(posedge clk_in) begin
        if (en_b_out) rd_d_b_in <= mem[addr_b_out];
    end

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } beat_t;

    beat_t       exp_q[$];
    logic [12:0] addr_q[$];
    int          pending_done = 0;
    int          outstanding  = 0;
    int          total_issues = 0;
    int          vectors      = 0;
    int          miscompares  = 0;
    bit          prev_stall   = 1'b0;
    logic [7:0]  prev_data    = '0;
    bit          rand_ready   = 1'b0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cmd_ready"}, 32'(cmd_ready_out), 32'd1);
        check({tag, "_en_b"},      32'(en_b_out),      32'd0);
        check({tag, "_addr_b"},    32'(addr_b_out),    32'd0);
        check({tag, "_we_b"},      32'(we_b_out),      32'd0);
        check({tag, "_data"},      32'(data_out),      32'd0);
        check({tag, "_valid"},     32'(valid_out),     32'd0);
        check({tag, "_last"},      32'(last_out),      32'd0);
        check({tag, "_done"},      32'(done_out),      32'd0);
    endtask

    // Scoreboard monitor: expands accepted commands and checks every output event
    always @(negedge clk_in) begin
        if (rst_n_in) begin
            if (done_out) begin
                if (pending_done == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    pending_done--;
                    check("done_bytes_left", 32'(exp_q.size()), 32'd0);
                end
            end
            if (cmd_valid_in && cmd_ready_out) begin
                for (int i = 0; i < int'(cmd_len_in); i++) begin
                    logic [12:0] a;
                    beat_t       b;
                    a = cmd_addr_in + 13'(i);
                    b.data = mem[a];
                    b.last = (i == int'(cmd_len_in) - 1);
                    addr_q.push_back(a);
                    exp_q.push_back(b);
                end
                pending_done++;
                $display("cmd addr=0x%04h len=%0d accepted", cmd_addr_in, cmd_len_in);
            end
            if (en_b_out) begin
                total_issues++;
                outstanding++;
                check("fifo_never_overflows", 32'(outstanding <= FIFO_DEPTH), 32'd1);
                check("we_b_low", 32'(we_b_out), 32'd0);
                if (addr_q.size() == 0) check("unexpected_issue", 32'(addr_b_out), 32'hFFFF_FFFF);
                else check("issue_addr", 32'(addr_b_out), 32'(addr_q.pop_front()));
            end
            if (prev_stall) begin
                check("valid_held", 32'(valid_out), 32'd1);
                check("data_held", 32'(data_out), 32'(prev_data));
            end
            if (valid_out && ready_in) begin
                outstanding--;
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", 32'(data_out), 32'hFFFF_FFFF);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("byte_data", 32'(data_out), 32'(e.data));
`ifdef BRAM_RD_STREAM_LAST_EN
                    check("byte_last", 32'(last_out), 32'(e.last));
`else
                    check("byte_last_off", 32'(last_out), 32'd0);
`endif
                end
            end
            prev_stall = valid_out && !ready_in;
            prev_data  = data_out;
        end
    end

    // Random downstream backpressure when enabled
    always @(posedge clk_in) begin
        if (rand_ready) begin
            #1;
            ready_in = ($urandom_range(0, 3) != 0);
        end
    end

    // Offer a command and return in the cycle after the handshake (cycle 1)
    task automatic send_cmd(input logic [12:0] a, input logic [13:0] l);
        bit ok;
        ok = 1'b0;
        cmd_addr_in  = a;
        cmd_len_in   = l;
        cmd_valid_in = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_in);
            if (cmd_ready_out) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("cmd_accept_timeout", 32'd0, 32'd1);
        @(posedge clk_in);
        #1;
        cmd_valid_in = 1'b0;
    endtask

    // Wait until every expected byte and done pulse has been seen
    task automatic wait_idle(input int limit);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(posedge clk_in);
            #1;
            if (pending_done == 0 && exp_q.size() == 0 && addr_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [12:0] a;
        int          base;
        bit          found;

        rst_n_in     = 1'b0;
        cmd_valid_in = 1'b0;
        cmd_addr_in  = '0;
        cmd_len_in   = '0;
        ready_in     = 1'b1;
        for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) mem[13'h010 + i] = 8'hA0 + 8'(i);

        #2;
        check_reset_values("reset");
        repeat (3) @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;

        // Basic 4-byte read: cycle-exact strobe/valid/done pattern
        send_cmd(13'h010, 14'd4);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk_in);
            check($sformatf("basic_en_c%0d", c),    32'(en_b_out),  32'(c <= 4));
            check($sformatf("basic_valid_c%0d", c), 32'(valid_out), 32'(c >= 3 && c <= 6));
            check($sformatf("basic_done_c%0d", c),  32'(done_out),  32'(c == 7));
        end
        wait_idle(100);

        // Address wrap 8191 -> 0
        send_cmd(13'h1FFE, 14'd4);
        wait_idle(100);

        // Backpressure: ready low in cycles 3..12
        send_cmd(13'($urandom), 14'd16);
        base = total_issues;
        @(posedge clk_in); #1;
        @(posedge clk_in); #1;
        ready_in = 1'b0;
        repeat (10) @(negedge clk_in);
        #1;
        check("stall_issue_count", 32'(total_issues - base), 32'(FIFO_DEPTH));
        check("stall_en_low", 32'(en_b_out), 32'd0);
        @(posedge clk_in); #1;
        ready_in = 1'b1;
        wait_idle(200);

        // Zero-length command
        send_cmd(13'h0123, 14'd0);
        @(negedge clk_in);
        check("zero_len_done_c1", 32'(done_out), 32'd1);
        check("zero_len_en", 32'(en_b_out), 32'd0);
        check("zero_len_valid", 32'(valid_out), 32'd0);
        wait_idle(50);

        // cmd_valid held: next command only in the done cycle (N+3)
        @(posedge clk_in); #1;
        cmd_addr_in  = 13'($urandom);
        cmd_len_in   = 14'd5;
        cmd_valid_in = 1'b1;
        @(negedge clk_in);
        check("held_first_accept", 32'(cmd_ready_out), 32'd1);
        @(posedge clk_in); #1;
        cmd_addr_in = 13'($urandom);
        cmd_len_in  = 14'd3;
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_in);
            if (cmd_ready_out) begin
                check("held_second_in_done_cycle", 32'(done_out), 32'd1);
                check("held_second_cycle", 32'(i + 1), 32'd8);
                found = 1'b1;
                break;
            end
        end
        if (!found) check("held_second_timeout", 32'd0, 32'd1);
        @(posedge clk_in); #1;
        cmd_valid_in = 1'b0;
        wait_idle(100);

        // Asynchronous reset in the middle of a 32-byte read
        send_cmd(13'($urandom), 14'd32);
        repeat (8) @(posedge clk_in);
        #2;
        rst_n_in = 1'b0;
        #1;
        check_reset_values("midcmd_reset");
        exp_q.delete();
        addr_q.delete();
        pending_done = 0;
        outstanding  = 0;
        prev_stall   = 1'b0;
        @(posedge clk_in);
        @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;
        send_cmd(13'($urandom), 14'd6);
        wait_idle(100);

        // Randomized commands under random backpressure
        rand_ready = 1'b1;
        for (int k = 0; k < 25; k++) begin
            a = 13'($urandom);
            send_cmd(a, (k % 8 == 0) ? 14'd0 : 14'($urandom_range(1, 40)));
            wait_idle(2000);
        end
        rand_ready = 1'b0;
        @(posedge clk_in); #2;
        ready_in = 1'b1;

        // Length beyond the buffer size re-reads from the wrapped start
        send_cmd(13'($urandom), 14'd8200);
        wait_idle(9000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
